// File: rtl/pipemem_pkg.sv
// Shared pipeline definitions for the MEM-stage sequencer: state encoding,
// default watchdog limit and datapath word width.
package pipemem_pkg;

  typedef enum logic [1:0] {
    PM_IDLE = 2'd0,
    PM_BUSY = 2'd1,
    PM_DONE = 2'd2
  } pm_state_t;

  localparam int PM_TIMEOUT_DEF = 255;
  localparam int PM_WORD_W      = 32;

endpackage

// File: rtl/pipemem_if.sv
// Data-memory request/acknowledge bus between the MEM-stage sequencer and
// the variable-latency data memory.
interface pipemem_if;

  logic                              mem_req;
  logic                              mem_we;
  logic [pipemem_pkg::PM_WORD_W-1:0] mem_addr;
  logic [pipemem_pkg::PM_WORD_W-1:0] mem_wdata;
  logic                              mem_ack;
  logic [pipemem_pkg::PM_WORD_W-1:0] mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                  input  mem_ack, mem_rdata);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                  output mem_ack, mem_rdata);

endinterface

// File: rtl/pipemem_wdog.sv
// BUSY-cycle watchdog for the MEM-stage sequencer; built only when
// PIPEMEM_TIMEOUT_EN is defined.
`ifdef PIPEMEM_TIMEOUT_EN
module pipemem_wdog #(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic busy,
  input  logic ack,
  output logic expire
);

  logic [TW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset)
      cnt <= '0;
    else if (start)
      cnt <= '0;
    else if (busy && !ack)
      cnt <= cnt + 1'b1;
  end

  // Fires on the TIMEOUT-th unacknowledged BUSY cycle; an ack always wins.
  assign expire = busy && !ack && (cnt == TW'(TIMEOUT - 1));

endmodule
`endif

// File: rtl/pipemem_ctrl.sv
// MEM-stage sequencer: issues data-memory requests, stalls the pipeline while
// an access is outstanding, and gates writeback. Option: PIPEMEM_TIMEOUT_EN.
module pipemem_ctrl
  import pipemem_pkg::*;
#(
  parameter int TIMEOUT = PM_TIMEOUT_DEF,
  parameter int TW      = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 mwreg,
  input  logic                 mm2reg,
  input  logic                 mwmem,
  input  logic [PM_WORD_W-1:0] malu,
  input  logic [PM_WORD_W-1:0] mb,
  pipemem_if.master            mem,
  output logic                 stall,
  output logic [PM_WORD_W-1:0] mdata,
  output logic                 wb_wreg,
  output logic                 misalign,
  output logic                 timeout
);

  if (TIMEOUT < 1 || TIMEOUT >= (1 << TW)) begin : g_bad_cfg
    $error("pipemem_ctrl: TIMEOUT must lie in 1 .. 2**TW-1");
  end

  pm_state_t state, nstate;
  logic      acc, mis, launch, expire, faulted, busy_ack;

  assign acc      = mm2reg | mwmem;
  assign mis      = acc & (malu[1:0] != 2'b00);
  assign busy_ack = (state == PM_BUSY) && mem.mem_ack;

  always_ff @(posedge clock) begin
    if (reset)
      state <= PM_IDLE;
    else
      state <= nstate;
  end

  always_comb begin
    nstate   = state;
    stall    = 1'b0;
    wb_wreg  = 1'b0;
    misalign = 1'b0;
    launch   = 1'b0;
    if (!reset) begin
      unique case (state)
        PM_IDLE: begin
          if (mis) begin
            misalign = 1'b1;
          end else if (acc) begin
            stall  = 1'b1;
            launch = 1'b1;
            nstate = PM_BUSY;
          end else begin
            wb_wreg = mwreg;
          end
        end
        PM_BUSY: begin
          stall = 1'b1;
          if (mem.mem_ack || expire)
            nstate = PM_DONE;
        end
        PM_DONE: begin
          wb_wreg = mwreg & ~faulted;
          nstate  = PM_IDLE;
        end
        default: nstate = PM_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      mdata         <= '0;
    end else begin
      if (launch) begin
        mem.mem_req   <= 1'b1;
        mem.mem_we    <= mwmem & ~mm2reg;
        mem.mem_addr  <= {malu[PM_WORD_W-1:2], 2'b00};
        mem.mem_wdata <= mb;
      end
      if (busy_ack) begin
        mem.mem_req <= 1'b0;
        if (!mem.mem_we)
          mdata <= mem.mem_rdata;
      end
`ifdef PIPEMEM_TIMEOUT_EN
      else if (expire) begin
        mem.mem_req <= 1'b0;
        mdata       <= '0;
      end
`endif
    end
  end

`ifdef PIPEMEM_TIMEOUT_EN
  pipemem_wdog #(.TIMEOUT(TIMEOUT), .TW(TW)) u_wdog (
    .clock  (clock),
    .reset  (reset),
    .start  (launch),
    .busy   (state == PM_BUSY),
    .ack    (mem.mem_ack),
    .expire (expire)
  );

  // faulted only lives for the DONE cycle of an abandoned access.
  always_ff @(posedge clock) begin
    if (reset) begin
      faulted <= 1'b0;
      timeout <= 1'b0;
    end else if (expire) begin
      faulted <= 1'b1;
      timeout <= 1'b1;
    end else if (state == PM_DONE) begin
      faulted <= 1'b0;
    end
  end
`else
  assign expire  = 1'b0;
  assign faulted = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: doc/pipemem_ctrl.md
# pipemem_ctrl

Sequencer for the MEM stage of the five-stage pipeline. It sits between the EX/MEM pipeline register and a variable-latency data memory with a req/ack handshake. It drives the memory request, freezes the upstream pipeline while an access is outstanding, captures load data for the MEM/WB register, and blocks register writeback on faulted accesses.

## Interface
Parameters:
- `TIMEOUT`, default 255: BUSY cycles without `mem_ack` before abandoning an access (used only with the timeout watchdog).
- `TW`, default 8: timeout counter width. Must satisfy `TIMEOUT < 2**TW`.

Ports:
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `mwreg`  in  1: EX/MEM register-write enable.
- `mm2reg`  in  1: EX/MEM load flag.
- `mwmem`  in  1: EX/MEM store flag.
- `malu`  in  32: byte address.
- `mb`  in  32: store data.
- `mem_req`  out  1: registered request to memory.
- `mem_we`  out  1: registered; 1 = store.
- `mem_addr`  out  32: registered; word-aligned byte address.
- `mem_wdata`  out  32: registered store data.
- `mem_ack`  in  1: memory completion, one-cycle pulse.
- `mem_rdata`  in  32: load data, valid with `mem_ack`.
- `stall`  out  1: combinational; freezes PC, IF/ID, ID/EX and EX/MEM.
- `mdata`  out  32: registered load result feeding MEM/WB.
- `wb_wreg`  out  1: combinational writeback enable feeding MEM/WB.
- `misalign`  out  1: combinational fault pulse.
- `timeout`  out  1: sticky registered fault flag.

## Operation
- Access condition: `acc = mm2reg | mwmem`. When both are set, treat it as a load, with `mem_we=0`.
- Misaligned access: `mis = acc & (malu[1:0]!=0)`.
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- IDLE, `acc & !mis`: latch `mem_addr=malu`, `mem_wdata=mb`, `mem_we=mwmem & !mm2reg`. Set `mem_req=1`, go to BUSY. `stall=1`.
- IDLE, `mis`: no request is issued. `misalign=1`, `stall=0`, `wb_wreg=0`. Stay in IDLE.
- IDLE, `!acc`: `stall=0`, `wb_wreg=mwreg`. Stay in IDLE.
- BUSY: `stall=1`, `mem_req` held at 1, `mem_addr`, `mem_we` and `mem_wdata` stable.
  - On `mem_ack`: `mdata<=mem_rdata` (loads only; stores leave `mdata` unchanged), `mem_req<=0`, go to DONE.
- DONE: `stall=0`, `wb_wreg=mwreg`. The pipeline advances on this edge, and MEM/WB captures `mdata`. Go to IDLE unconditionally.
- `mem_ack` is ignored in IDLE and DONE.
- `wb_wreg` is 0 whenever `stall=1`, so no duplicate writeback occurs.
- Reset values: `mem_req=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `mdata=0`, `timeout=0`.
  - Combinational outputs are forced to 0 while `reset=1`.
- Reset asserted mid-access: next edge returns to IDLE with `mem_req=0`. Any later `mem_ack` is ignored.

## Timing
- Cycle 0 (IDLE): access detected, `stall=1`.
- Cycle 1: `mem_req=1`.
- `mem_ack` sampled in cycle k ≥ 1 means DONE in cycle k+1, and the instruction leaves MEM at the end of cycle k+1.
- Minimum MEM occupancy is 3 cycles, including 2 stall cycles.
- Non-memory instructions take 1 cycle with no stall.
- Back-to-back memory instructions each pay their full cost. DONE is never skipped.

## Configuration
- `PIPEMEM_TIMEOUT_EN` defined:
  - A `TW`-bit counter clears on entry to BUSY and increments each BUSY cycle without `mem_ack`.
  - When the counter reaches `TIMEOUT` while BUSY with no ack: `mem_req<=0`, `mdata<=32'h0`, `timeout<=1` (sticky until reset), go to DONE.
  - The faulted instruction's `wb_wreg` is forced to 0 in that DONE cycle.
  - Ack and timeout in the same cycle: the ack wins.
- Not defined: BUSY waits indefinitely, `timeout` is tied to 0, and no counter is built.

## Structure
- Shared pipeline package holds:
  - the state encoding (`PM_IDLE=2'd0`, `PM_BUSY=2'd1`, `PM_DONE=2'd2`),
  - the default `TIMEOUT`,
  - the 32-bit word width constant.
- Single module. An optional sub-module `pipemem_wdog` encapsulates the timeout counter under the macro.

## Test plan
- Load at `malu=32'h0000_0010`, memory acks after 3 cycles with `mem_rdata=32'h1234_5678` -> `mem_req` high for 3 cycles, `stall` for 4 cycles, `mdata=32'h1234_5678`, `wb_wreg=1` only in DONE.
- Store `mb=32'hCAFE_F00D` at `32'h20`, ack in the first request cycle -> `mem_we=1`, `mem_wdata=32'hCAFE_F00D`, exactly 2 stall cycles, `mdata` unchanged.
- Load at `malu=32'h0000_0013` -> `mem_req` never asserted, `misalign=1` for 1 cycle, `stall=0`, `wb_wreg=0`.
- ALU instruction (`mwreg=1`, no memory flags) -> `stall=0`, `wb_wreg=1`, `mem_req=0`. Spurious `mem_ack` in IDLE has no effect.
- `reset` pulsed in the 2nd BUSY cycle -> next cycle: IDLE, `mem_req=0`, `stall=0`, `mdata=0`. A later ack is ignored.
- With `PIPEMEM_TIMEOUT_EN` and `TIMEOUT=4`, no ack -> `mem_req` drops after 4 BUSY cycles, `timeout=1` stays set, DONE with `wb_wreg=0`, `mdata=0`.
